// File: rtl/qspi_flash_arbiter.sv
// ---------------------------------------------------------------------------
// qspi_flash_arbiter
//
// Shares one QSPI flash read engine between two requesters:
//   port C - cache line refill
//   port D - uncached / direct data read
// Requests are arbitrated round-robin while the engine reports idle. Each
// accepted request launches exactly one engine read. Returned words are
// counted and routed to the owning port, which then receives a done pulse.
// If the engine goes quiet for TIMEOUT cycles, the transaction is aborted
// with err=1.
//
// Ports (all in the aclk domain):
//   aclk, aresetn          clock, asynchronous active-low reset
//   c_req/c_addr/c_len     port C request (held until c_ack)
//   c_ack                  port C accepted (combinational, same cycle as win)
//   c_rvalid, c_done       port C data valid / transaction finished
//   d_*                    same set for port D
//   rdata                  returned word, shared by both ports
//   err                    qualifies c_done/d_done: 1 = timeout abort
//   qspi_addr/qspi_nwords  engine read address and word count
//   qspi_read_en           engine start pulse
//   qspi_dout/qspi_dval    engine data and data valid
//   qspi_rready            engine idle and able to take a start
// ---------------------------------------------------------------------------
module qspi_flash_arbiter #(
    parameter int unsigned MAXLEN  = 4,
    parameter int unsigned TIMEOUT = 1024,
    localparam int unsigned LENW   = $clog2(MAXLEN + 1)
) (
    input  logic            aclk,
    input  logic            aresetn,

    input  logic            c_req,
    input  logic [23:0]     c_addr,
    input  logic [LENW-1:0] c_len,
    output logic            c_ack,
    output logic            c_rvalid,
    output logic            c_done,

    input  logic            d_req,
    input  logic [23:0]     d_addr,
    input  logic [LENW-1:0] d_len,
    output logic            d_ack,
    output logic            d_rvalid,
    output logic            d_done,

    output logic [31:0]     rdata,
    output logic            err,

    output logic [23:0]     qspi_addr,
    output logic [LENW-1:0] qspi_nwords,
    output logic            qspi_read_en,
    input  logic [31:0]     qspi_dout,
    input  logic            qspi_dval,
    input  logic            qspi_rready
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_e;

    // Owner / last-grant encoding: 0 = port C, 1 = port D.
    state_e            state_q, state_d;
    logic [23:0]       addr_q, addr_d;
    logic [LENW-1:0]   len_q, len_d;
    logic              owner_q, owner_d;
    logic              last_gnt_q, last_gnt_d;
    logic [LENW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              c_rvalid_q, c_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;

    logic              arb_ok;
    logic              gnt_c;
    logic              gnt_d;
    logic              busy;

    // Zero-length requests still fetch one word; oversize requests are cut
    // to the largest burst the engine is configured for.
    function automatic logic [LENW-1:0] clamp_len(input logic [LENW-1:0] len);
        logic [LENW-1:0] res;
        if (len == '0) begin
            res = LENW'(1);
        end else if (len > LENW'(MAXLEN)) begin
            res = LENW'(MAXLEN);
        end else begin
            res = len;
        end
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // Arbitration: only in IDLE with the engine ready. On a tie the port that
    // did not win last time is granted.
    // -----------------------------------------------------------------------
    always_comb begin
        arb_ok = (state_q == StIdle) && qspi_rready;
        gnt_c  = arb_ok && c_req && (!d_req || last_gnt_q);
        gnt_d  = arb_ok && d_req && (!c_req || !last_gnt_q);
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        tcnt_d     = tcnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        c_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (gnt_c) begin
                    addr_d  = c_addr;
                    len_d   = clamp_len(c_len);
                    owner_d = 1'b0;
                    state_d = StIssue;
                end else if (gnt_d) begin
                    addr_d  = d_addr;
                    len_d   = clamp_len(d_len);
                    owner_d = 1'b1;
                    state_d = StIssue;
                end
            end

            StIssue: begin
                cnt_d   = '0;
                tcnt_d  = '0;
                state_d = StWait;
            end

            StWait: begin
                if (qspi_dval) begin
                    rdata_d    = qspi_dout;
                    c_rvalid_d = !owner_q;
                    d_rvalid_d = owner_q;
                    cnt_d      = cnt_q + LENW'(1);
                    tcnt_d     = '0;
                    if (cnt_q == len_q - LENW'(1)) begin
                        err_d   = 1'b0;
                        state_d = StDone;
                    end
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end

            StDone: begin
                last_gnt_d = owner_q;
                state_d    = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            len_q      <= '0;
            owner_q    <= 1'b0;
            last_gnt_q <= 1'b1;
            cnt_q      <= '0;
            tcnt_q     <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
            tcnt_q     <= tcnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            c_rvalid_q <= c_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        busy         = (state_q != StIdle);
        c_ack        = gnt_c;
        d_ack        = gnt_d;
        qspi_read_en = (state_q == StIssue);
        qspi_addr    = busy ? addr_q : '0;
        qspi_nwords  = busy ? len_q : '0;
        c_done       = (state_q == StDone) && !owner_q;
        d_done       = (state_q == StDone) && owner_q;
        c_rvalid     = c_rvalid_q;
        d_rvalid     = d_rvalid_q;
        rdata        = rdata_q;
        err          = err_q;
    end

    // -----------------------------------------------------------------------
    // Protocol invariants
    // -----------------------------------------------------------------------
    a_single_ack: assert property (@(posedge aclk) disable iff (!aresetn)
        !(c_ack && d_ack));

    a_read_en_pulse: assert property (@(posedge aclk) disable iff (!aresetn)
        qspi_read_en |=> !qspi_read_en);

    a_single_rvalid: assert property (@(posedge aclk) disable iff (!aresetn)
        !(c_rvalid && d_rvalid));

    a_single_done: assert property (@(posedge aclk) disable iff (!aresetn)
        !(c_done && d_done));

endmodule

// File: tb/tb_qspi_flash_arbiter.sv
module tb_qspi_flash_arbiter;

    localparam int unsigned MAXLEN  = 4;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned LENW    = 3;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic            c_req, d_req;
    logic [23:0]     c_addr, d_addr;
    logic [LENW-1:0] c_len, d_len;
    logic            c_ack, c_rvalid, c_done;
    logic            d_ack, d_rvalid, d_done;
    logic [31:0]     rdata;
    logic            err;
    logic [23:0]     qspi_addr;
    logic [LENW-1:0] qspi_nwords;
    logic            qspi_read_en;
    logic [31:0]     qspi_dout;
    logic            qspi_dval;
    logic            qspi_rready;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 aclk = ~aclk;

    qspi_flash_arbiter #(
        .MAXLEN  (MAXLEN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .c_req        (c_req),
        .c_addr       (c_addr),
        .c_len        (c_len),
        .c_ack        (c_ack),
        .c_rvalid     (c_rvalid),
        .c_done       (c_done),
        .d_req        (d_req),
        .d_addr       (d_addr),
        .d_len        (d_len),
        .d_ack        (d_ack),
        .d_rvalid     (d_rvalid),
        .d_done       (d_done),
        .rdata        (rdata),
        .err          (err),
        .qspi_addr    (qspi_addr),
        .qspi_nwords  (qspi_nwords),
        .qspi_read_en (qspi_read_en),
        .qspi_dout    (qspi_dout),
        .qspi_dval    (qspi_dval),
        .qspi_rready  (qspi_rready)
    );

    // flags = {c_ack, d_ack, read_en, c_rvalid, d_rvalid, c_done, d_done, err}
    typedef struct packed {
        logic [7:0]      flags;
        logic [23:0]     qa;
        logic [LENW-1:0] nw;
        logic [31:0]     rd;
    } out_t;

    typedef struct {
        logic            cr;
        logic [23:0]     ca;
        logic [LENW-1:0] cl;
        logic            dr;
        logic [23:0]     da;
        logic [LENW-1:0] dl;
        logic            rr;
        logic            dv;
        logic [31:0]     dt;
        out_t            exp;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic cr, input logic [23:0] ca, input logic [LENW-1:0] cl,
                                input logic dr, input logic [23:0] da, input logic [LENW-1:0] dl,
                                input logic rr, input logic dv, input logic [31:0] dt,
                                input logic [7:0] fl, input logic [23:0] qa,
                                input logic [LENW-1:0] nw, input logic [31:0] rd);
        vec_t v;
        v.cr = cr; v.ca = ca; v.cl = cl;
        v.dr = dr; v.da = da; v.dl = dl;
        v.rr = rr; v.dv = dv; v.dt = dt;
        v.exp.flags = fl; v.exp.qa = qa; v.exp.nw = nw; v.exp.rd = rd;
        return v;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.flags = {c_ack, d_ack, qspi_read_en, c_rvalid, d_rvalid, c_done, d_done, err};
        o.qa    = qspi_addr;
        o.nw    = qspi_nwords;
        o.rd    = rdata;
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        c_req = 1'b0; c_addr = '0; c_len = '0;
        d_req = 1'b0; d_addr = '0; d_len = '0;
        qspi_dout = '0; qspi_dval = 1'b0; qspi_rready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int n;
        logic found;

        // ---------------- Table: C refill of 4 words, then D with len=0 ---------
        vecs[0]  = mk(1, 24'h001000, 4, 0, 0, 0, 1, 0, 0,            8'b1000_0000, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0,                     8'b0010_0000, 24'h001000, 4, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 32'hA0,                8'b0000_0000, 24'h001000, 4, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 32'hA1,                8'b0001_0000, 24'h001000, 4, 32'hA0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 32'hA2,                8'b0001_0000, 24'h001000, 4, 32'hA1);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 32'hA3,                8'b0001_0000, 24'h001000, 4, 32'hA2);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0,                     8'b0001_0100, 24'h001000, 4, 32'hA3);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0,                     8'b0000_0000, 0, 0, 32'hA3);
        vecs[8]  = mk(0, 0, 0, 1, 24'h000200, 0, 1, 0, 0,            8'b0100_0000, 0, 0, 32'hA3);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0,                     8'b0010_0000, 24'h000200, 1, 32'hA3);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF,          8'b0000_0000, 24'h000200, 1, 32'hA3);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0,                     8'b0000_1010, 24'h000200, 1, 32'hDEADBEEF);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h12345678,          8'b0000_0000, 0, 0, 32'hDEADBEEF);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0,                     8'b0000_0000, 0, 0, 32'hDEADBEEF);

        do_reset();
        chk("reset_outputs", sample(), '0);

        for (int i = 0; i < 14; i++) begin
            c_req = vecs[i].cr; c_addr = vecs[i].ca; c_len = vecs[i].cl;
            d_req = vecs[i].dr; d_addr = vecs[i].da; d_len = vecs[i].dl;
            qspi_rready = vecs[i].rr; qspi_dval = vecs[i].dv; qspi_dout = vecs[i].dt;
            #1;
            chk($sformatf("vec%0d", i), sample(), vecs[i].exp);
            tick();
        end

        // ---------------- Round-robin: C, D, C from reset -----------------------
        do_reset();
        c_req = 1; d_req = 1; c_len = 1; d_len = 1;
        c_addr = 24'h000100; d_addr = 24'h000200;
        #1;
        chk("tie1_ack", {c_ack, d_ack}, 2'b10);
        tick(); c_req = 0; #1;
        chk("tie1_issue", {qspi_read_en, d_ack, qspi_addr}, {2'b10, 24'h000100});
        tick(); qspi_dval = 1; qspi_dout = 32'h11; #1;
        chk("busy_no_d_ack", d_ack, 1'b0);
        tick(); qspi_dval = 0; c_req = 1; #1;
        chk("tie1_done", {c_done, d_done, c_ack, d_ack, c_rvalid, err}, 6'b100010);
        tick(); #1;
        chk("tie2_ack", {c_ack, d_ack}, 2'b01);
        tick(); d_req = 0; #1;
        chk("tie2_issue", {qspi_read_en, qspi_addr, qspi_nwords}, {1'b1, 24'h000200, 3'd1});
        tick(); qspi_dval = 1; qspi_dout = 32'h22;
        tick(); qspi_dval = 0; #1;
        chk("tie2_done", {c_done, d_done, d_rvalid, c_ack, rdata}, {4'b0110, 32'h22});
        tick(); #1;
        chk("tie3_ack", {c_ack, d_ack}, 2'b10);
        tick(); c_req = 0;
        tick(); qspi_dval = 1; qspi_dout = 32'h33;
        tick(); qspi_dval = 0; #1;
        chk("tie3_done", {c_done, d_done, c_rvalid, rdata}, {3'b101, 32'h33});
        tick();

        // ---------------- rready held low, then oversize length -----------------
        qspi_rready = 0; c_req = 1; c_len = 7; c_addr = 24'h00ABC0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (c_ack || qspi_read_en) bad++;
            tick();
        end
        chk("rready_low_hold", bad, 0);
        qspi_rready = 1; #1;
        chk("rready_rise_ack", c_ack, 1'b1);
        tick(); c_req = 0; #1;
        chk("clamp_nwords", {qspi_read_en, qspi_nwords, qspi_addr}, {1'b1, 3'd4, 24'h00ABC0});
        for (int w = 0; w < 4; w++) begin
            tick(); qspi_dval = 1; qspi_dout = 32'hB0 + w;
        end
        tick(); qspi_dval = 0; #1;
        chk("clamp_done", {c_rvalid, c_done, err, rdata}, {3'b110, 32'hB3});
        tick();

        // ---------------- Timeout after 2 of 4 words -----------------------------
        c_req = 1; c_len = 4; c_addr = 24'h002000; #1;
        chk("to_ack", c_ack, 1'b1);
        tick(); c_req = 0;
        tick(); qspi_dval = 1; qspi_dout = 32'hC0;
        tick(); qspi_dval = 1; qspi_dout = 32'hC1;
        tick(); qspi_dval = 0; #1;
        chk("to_word2", {c_rvalid, c_done, rdata}, {2'b10, 32'hC1});
        n = 0; found = 0; bad = 0;
        while (n < 40 && !found) begin
            tick();
            n++;
            if (c_done) found = 1;
            else if (c_rvalid) bad++;
        end
        chk("timeout_cycles", n, 16);
        chk("timeout_done_err", {c_done, err, c_rvalid, d_done}, 4'b1100);
        chk("timeout_no_rvalid", bad, 0);
        tick(); qspi_dval = 1; qspi_dout = 32'hEE;
        tick(); qspi_dval = 0; #1;
        chk("stray_ignored", {c_rvalid, d_rvalid, err, rdata}, {3'b001, 32'hC1});

        // ---------------- Reset in WAIT, then normal request ---------------------
        tick();
        c_req = 1; c_len = 4; c_addr = 24'h003000; #1;
        chk("rst_pre_ack", c_ack, 1'b1);
        tick(); c_req = 0;
        tick(); qspi_dval = 1; qspi_dout = 32'hD0;
        tick(); qspi_dval = 0;
        aresetn = 0; #1;
        chk("rst_mid_outputs", sample(), '0);
        qspi_dval = 1; qspi_dout = 32'hFF;
        tick(); tick();
        aresetn = 1;
        tick(); qspi_dval = 0; #1;
        chk("rst_inflight_ignored", sample(), '0);
        c_req = 1; c_len = 2; c_addr = 24'h004000; #1;
        chk("rst_next_ack", {c_ack, qspi_addr}, {1'b1, 24'h0});
        tick(); c_req = 0; #1;
        chk("rst_next_issue", {qspi_read_en, qspi_addr, qspi_nwords}, {1'b1, 24'h004000, 3'd2});
        tick(); qspi_dval = 1; qspi_dout = 32'hE0;
        tick(); qspi_dval = 1; qspi_dout = 32'hE1;
        tick(); qspi_dval = 0; #1;
        chk("rst_next_done", {c_rvalid, c_done, err, rdata}, {3'b110, 32'hE1});
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
